// File: rtl/rxm_bar_responder.sv
// rxm_bar_responder: Avalon-MM burst slave backed by on-chip RAM for the PCIe BAR0/1 rxm port.
// Optional macro RXM_RD_PIPE_EN adds one output register stage on readdata/read_valid.
module rxm_bar_responder #(
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned BURST_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxm_read_bar_0_1,
  input  logic                   rxm_write_bar_0_1,
  input  logic [ADDR_WIDTH-1:0]  rxm_address_bar_0_1,
  input  logic [63:0]            rxm_writedata_bar_0_1,
  input  logic [7:0]             rxm_byteenable_bar_0_1,
  input  logic [BURST_WIDTH-1:0] rxm_burst_count_bar_0_1,
  output logic                   rxm_wait_request_bar_0_1,
  output logic [63:0]            rxm_readdata_bar_0_1,
  output logic                   rxm_read_valid_bar_0_1
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

  state_e                 state_q, state_d;
  logic                   reset_hold_q;
  logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0] count_q, count_d;
  logic [DEPTH_LOG2-1:0]  cmd_addr;
  logic [BURST_WIDTH-1:0] cmd_count;
  logic                   accept_wr, accept_rd;
  logic                   wait_request, mem_we, rd_issue;
  logic [DEPTH_LOG2-1:0]  mem_waddr;
  logic [63:0]            rd_data_q;
  logic                   rd_valid_q;
  logic [63:0]            mem [Depth];

  // Byte offset and high address bits alias onto the RAM.
  logic unused_addr;
  assign unused_addr = ^{rxm_address_bar_0_1[2:0],
                         rxm_address_bar_0_1[ADDR_WIDTH-1:DEPTH_LOG2+3]};

  assign cmd_addr  = rxm_address_bar_0_1[DEPTH_LOG2+2:3];
  assign cmd_count = (rxm_burst_count_bar_0_1 == '0) ? BURST_WIDTH'(1)
                                                     : rxm_burst_count_bar_0_1;

  // In idle, wait_request is only the post-reset hold; write wins over a concurrent read.
  assign accept_wr = (state_q == StIdle) && rxm_write_bar_0_1 && !reset_hold_q;
  assign accept_rd = (state_q == StIdle) && rxm_read_bar_0_1 && !rxm_write_bar_0_1 &&
                     !reset_hold_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      reset_hold_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      reset_hold_q <= 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept_wr) begin
          if (cmd_count != BURST_WIDTH'(1)) state_d = StWrBurst;
        end else if (accept_rd) begin
          state_d = StRdBurst;
        end
      end
      StWrBurst: begin
        if (rxm_write_bar_0_1 && (count_q == BURST_WIDTH'(1))) state_d = StIdle;
      end
      StRdBurst: begin
        if (count_q == BURST_WIDTH'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    wait_request = reset_hold_q || (state_q == StRdBurst);
    mem_we       = accept_wr || ((state_q == StWrBurst) && rxm_write_bar_0_1);
    mem_waddr    = (state_q == StIdle) ? cmd_addr : addr_q;
    rd_issue     = (state_q == StRdBurst);
  end

  assign rxm_wait_request_bar_0_1 = wait_request;

  // Burst address/count: write holds beats remaining after beat 0, read holds beats to issue.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (accept_wr) begin
      addr_d  = cmd_addr + DEPTH_LOG2'(1);
      count_d = cmd_count - BURST_WIDTH'(1);
    end else if (accept_rd) begin
      addr_d  = cmd_addr;
      count_d = cmd_count;
    end else if (((state_q == StWrBurst) && rxm_write_bar_0_1) || rd_issue) begin
      addr_d  = addr_q + DEPTH_LOG2'(1);
      count_d = count_q - BURST_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (rxm_byteenable_bar_0_1[i]) begin
          mem[mem_waddr][8*i +: 8] <= rxm_writedata_bar_0_1[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      if (rd_issue) rd_data_q <= mem[addr_q];
    end
  end

`ifdef RXM_RD_PIPE_EN
  logic [63:0] pipe_data_q;
  logic        pipe_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_data_q  <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      pipe_valid_q <= rd_valid_q;
      if (rd_valid_q) pipe_data_q <= rd_data_q;
    end
  end

  assign rxm_readdata_bar_0_1   = pipe_data_q;
  assign rxm_read_valid_bar_0_1 = pipe_valid_q;
`else
  assign rxm_readdata_bar_0_1   = rd_data_q;
  assign rxm_read_valid_bar_0_1 = rd_valid_q;
`endif

endmodule
